// File: rtl/fadd_rr_arbiter.sv
// Round-robin arbiter sharing one combinational FP32 adder between NUM_REQ
// requesters; the sum is captured in a single output register tagged by requester.

module fadd (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_sum
);
  logic        w_exc_in;
  logic        w_swap;
  logic [31:0] w_big;
  logic [31:0] w_small;
  logic [7:0]  w_shift;
  logic [26:0] w_mbig;
  logic [26:0] w_msmall;
  logic [26:0] w_sum;
  logic [4:0]  w_lz;
  logic [9:0]  w_exp;

  assign w_exc_in = (&i_a[30:23]) || (&i_b[30:23]);
  assign w_swap   = i_b[30:0] > i_a[30:0];
  assign w_big    = w_swap ? i_b : i_a;
  assign w_small  = w_swap ? i_a : i_b;
  assign w_shift  = w_big[30:23] - w_small[30:23];

  // Subnormals flush to zero; two guard bits survive alignment, result truncates.
  assign w_mbig   = (|w_big[30:23])   ? {2'b01, w_big[22:0], 2'b00} : '0;
  assign w_msmall = (|w_small[30:23]) ? ({2'b01, w_small[22:0], 2'b00} >> w_shift) : '0;
  assign w_sum    = (w_big[31] == w_small[31]) ? (w_mbig + w_msmall) : (w_mbig - w_msmall);

  always_comb begin
    w_lz = '0;
    for (int unsigned i = 0; i < 27; i++) begin
      if (w_sum[i]) w_lz = 5'(26 - i);
    end
  end

  assign w_exp = {2'b00, w_big[30:23]} + 10'd1 - {5'b00000, w_lz};

  always_comb begin
    o_sum = '0;
    if (!w_exc_in && (w_sum != '0) && !w_exp[9] && (w_exp != '0) && (w_exp < 10'd255))
      o_sum = {w_big[31], w_exp[7:0], 23'((w_sum << w_lz) >> 3)};
  end
endmodule

module fadd_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int BIT_W   = 32,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*BIT_W-1:0] req_a,
  input  logic [NUM_REQ*BIT_W-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [BIT_W-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic [31:0]              op_count
);
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_rsp_id;
  logic [ID_W-1:0]  w_gnt_id;
  logic [ID_W-1:0]  w_ptr_nxt;
  logic [BIT_W-1:0] r_rsp_data;
  logic [BIT_W-1:0] w_op_a;
  logic [BIT_W-1:0] w_op_b;
  logic [BIT_W-1:0] w_sum;
  logic             r_rsp_valid;
  logic             w_slot_free;
  logic             w_any;
  logic             w_accept;
  logic [31:0]      r_op_count;

  // First valid requester at or after r_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    w_any    = 1'b0;
    w_gnt_id = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(r_ptr) + k) % NUM_REQ;
      if (!w_any && req_valid[idx]) begin
        w_any    = 1'b1;
        w_gnt_id = ID_W'(idx);
      end
    end
  end

  assign w_slot_free = !r_rsp_valid || rsp_ready;
  assign w_accept    = w_any && w_slot_free && !rst;

  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[w_gnt_id] = 1'b1;
  end

  assign w_op_a    = req_a[w_gnt_id*BIT_W +: BIT_W];
  assign w_op_b    = req_b[w_gnt_id*BIT_W +: BIT_W];
  assign w_ptr_nxt = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;

  fadd u_fadd (
    .i_a   (w_op_a),
    .i_b   (w_op_b),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_op_count  <= '0;
      r_ptr       <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_data  <= w_sum;
      r_rsp_id    <= w_gnt_id;
      r_ptr       <= w_ptr_nxt;
      if (r_op_count != '1) r_op_count <= r_op_count + 32'd1;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign op_count  = r_op_count;
endmodule

// File: doc/fadd_rr_arbiter.md
# fadd_rr_arbiter

Round-robin arbiter and sequencer that shares one combinational FP32 adder (`fadd`) between `NUM_REQ` requesters. Each requester presents an operand pair over a valid/ready handshake. The arbiter grants at most one requester per cycle, drives the shared `fadd`, and captures the sum in a single output register tagged with the requester ID. It sits between compute lanes (e.g. softmax/layernorm accumulation lanes) and the one adder instance, so area is not replicated per lane.

## Interface
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `BIT_W`, default 32: operand/result width, IEEE-754 single.
- `ID_W`, default `$clog2(NUM_REQ)`: requester tag width (derived, not overridden).

Clock and reset are fixed: one clock; reset is synchronous and active-high.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester operand valid.
- `req_ready`  out  NUM_REQ  per-requester accept; at most one bit high.
- `req_a`  in  NUM_REQ*BIT_W  flattened operand A; requester i at `[i*BIT_W +: BIT_W]`.
- `req_b`  in  NUM_REQ*BIT_W  flattened operand B, same packing.
- `rsp_valid`  out  1  result register holds a valid sum.
- `rsp_ready`  in  1  downstream accepts result.
- `rsp_data`  out  BIT_W  registered `fadd` result.
- `rsp_id`  out  ID_W  index of the requester that owns `rsp_data`.
- `op_count`  out  32  number of accepted operations; saturates at `32'hFFFFFFFF`.

## Operation
- The single `fadd` instance is internal. Its inputs are muxed from the granted requester's `req_a`/`req_b`.
- Slot free condition: `slot_free = !rsp_valid || rsp_ready`.
- Grant selection:
  - Search starts at priority pointer `ptr` and wraps modulo `NUM_REQ`.
  - The first i with `req_valid[i]` wins.
  - `req_ready[i]` is high only for the winner, and only when `slot_free`.
- Accept: `req_valid[i] && req_ready[i]` at a rising edge.
- On accept:
  - `rsp_data <= fadd(a_i, b_i)`, `rsp_id <= i`, `rsp_valid <= 1`.
  - `ptr <= (i+1) mod NUM_REQ`.
  - `op_count` increments (saturating).
- Drain without accept (`rsp_valid && rsp_ready`, no grant): `rsp_valid <= 0`. `ptr`, `rsp_data` and `rsp_id` are held.
- Drain with accept in the same cycle: the new result replaces the old one and `rsp_valid` stays 1. This is a back-to-back transfer, not a bubble.
- Stall (`rsp_valid && !rsp_ready`):
  - All `req_ready` are 0.
  - The output register holds; `ptr` holds.
- No requests: `ptr` holds, so fairness is not reset by idle cycles.
- Arithmetic is entirely `fadd`'s. Exceptional inputs (Inf/NaN) yield `fadd`'s exception output `32'h00000000`, passed through unchanged. The arbiter adds no flags.
- Requesters must hold `req_valid`, `req_a` and `req_b` stable until accepted. The arbiter does not latch unaccepted operands.
- Reset values:
  - `rsp_valid=0`, `rsp_data=0`, `rsp_id=0`, `op_count=0`, `ptr=0`.
  - `req_ready=0` throughout any cycle in which `rst` is high.
- Reset mid-operation: any held result is discarded with no `rsp_valid` pulse. The first cycle after reset deasserts behaves as idle with requester 0 at top priority.

## Timing
- `req_ready` is combinational from `req_valid`, `rsp_valid`, `rsp_ready` and `ptr`. It is the only combinational in→out path.
- Latency: operands accepted at edge k; `rsp_valid`/`rsp_data`/`rsp_id` valid after edge k, i.e. in cycle k+1.
- Throughput: 1 op/cycle when `rsp_ready` is held high.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NUM_REQ-1,0. Worst-case wait is NUM_REQ-1 grants.
- `fadd` critical path sits between the input mux and the `rsp_data` register. No additional pipeline stage.

## Test plan
- Single request: after reset, req0 = `4048F5C3` + `3FC00000`, `rsp_ready=1`.
  - `req_ready=4'b0001` in the same cycle.
  - Next cycle: `rsp_valid=1`, `rsp_data=40947AE1`, `rsp_id=0`, `op_count=1`.
- Round-robin: all four requesters valid continuously (req2 = `C048F5C3` + `BFC00000`), `rsp_ready=1`.
  - `rsp_id` sequence is 0,1,2,3,0.
  - The id 2 result is `C0947AE1`.
- Backpressure: hold `rsp_ready=0` for 3 cycles with req1 valid.
  - `req_ready=0` throughout; `rsp_data`/`rsp_id` stable.
  - On `rsp_ready=1`: req1 is accepted in that same cycle, and the new result replaces the old with no bubble.
- Pointer retention: grant req3, idle 5 cycles, then assert req0 and req3 together → req0 wins (`ptr=0` after req3 grant).
- Exception passthrough: req0 = `7F800000` + `7F800000` → `rsp_data=00000000`, `rsp_valid=1`. Then `00000000` + `4048F5C3` → `4048F5C3`.
- Reset mid-stall: `rsp_valid=1`, `rsp_ready=0`, assert `rst` for 1 cycle.
  - `rsp_valid=0`, `op_count=0`.
  - Next request from req2 with req0 also valid → req0 granted first.
